// File: rtl/caches_pkg.sv
// Types and constants shared by the caches and the memory arbiter.
package caches_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/caches_if.sv
// Cache-to-memory request/response bundle; master is the cache side, slave the arbiter.
interface caches_if;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iwait, iload, dwait, dload
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output iwait, iload, dwait, dload
  );

endinterface

// File: rtl/memory_arbiter.sv
// Serialises icache and dcache word requests onto the single RAM port,
// favouring the dcache but bounding how long an icache request can starve.
module memory_arbiter
  import caches_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  caches_if.slave     cif,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             d_req;

  assign d_req = cif.dREN | cif.dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Completion is combinational from ramstate; an owner dropping its request
  // before ACCESS releases the port with no completion.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    cif.iwait   = 1'b1;
    cif.iload   = '0;
    cif.dwait   = 1'b1;
    cif.dload   = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      ARB_IDLE: begin
        if (!cif.iREN) begin
          starve_next = '0;
        end
        if (cif.iREN && d_req) begin
          state_next = (starve_cnt == CNT_MAX) ? ARB_I : ARB_D;
        end else if (cif.iREN) begin
          state_next = ARB_I;
        end else if (d_req) begin
          state_next = ARB_D;
        end
      end

      ARB_I: begin
        if (!cif.iREN) begin
          state_next = ARB_IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = cif.iaddr;
          if (ramstate == ACCESS) begin
            cif.iwait   = 1'b0;
            cif.iload   = ramload;
            starve_next = '0;
            state_next  = ARB_IDLE;
          end
        end
      end

      ARB_D: begin
        if (!d_req) begin
          state_next = ARB_IDLE;
        end else begin
          ramREN   = cif.dREN;
          ramWEN   = cif.dWEN;
          ramaddr  = cif.daddr;
          ramstore = cif.dstore;
          if (ramstate == ACCESS) begin
            cif.dwait  = 1'b0;
            cif.dload  = cif.dREN ? ramload : '0;
            state_next = ARB_IDLE;
            if (cif.iREN && (starve_cnt != CNT_MAX)) begin
              starve_next = starve_cnt + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural RAM responder plus
// per-side scoreboards of expected completion data.
module tb_memory_arbiter;
  import caches_pkg::*;

  logic        CLK;
  logic        RST;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  caches_if cif ();

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .cif      (cif),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checkCount = 0;
  int passCount  = 0;
  int ramWaitCfg = 0;
  int ramCount   = 0;
  bit ramErr     = 1'b0;
  int doneSide   = 0;

  logic [31:0] iQ[$];
  logic [31:0] dQ[$];
  logic [31:0] mem[logic [31:0]];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return {addr[15:0], 16'hC0DE};
  endfunction

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dRd,
                               input logic dWr, input logic [31:0] dAddr, input logic [31:0] dData);
    cif.iREN   = iReq;
    cif.iaddr  = iAddr;
    cif.dREN   = dRd;
    cif.dWEN   = dWr;
    cif.daddr  = dAddr;
    cif.dstore = dData;
  endtask

  // One cycle: RAM responder reacts to the strobes, then completions are scored.
  task automatic stepCycle();
    @(negedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      if (ramCount >= ramWaitCfg) begin
        ramstate = ACCESS;
        ramload  = ramREN ? memWord(ramaddr) : 32'hBAD0_0001;
        if (ramWEN) mem[ramaddr] = ramstore;
        ramCount = 0;
      end else begin
        ramstate = ramErr ? ERROR : BUSY;
        ramload  = 32'hBAD0_0002;
        ramCount++;
      end
    end else begin
      ramstate = FREE;
      ramload  = 32'hBAD0_0003;
      ramCount = 0;
    end
    #1;
    doneSide = 0;
    if (cif.iwait === 1'b0) begin
      doneSide = 1;
      if (iQ.size() != 0) checkOutput("iload", cif.iload, iQ.pop_front());
      else checkOutput("iSpuriousDone", 32'(cif.iwait), 32'd1);
    end else begin
      checkOutput("iloadIdle", cif.iload, 32'd0);
    end
    if (cif.dwait === 1'b0) begin
      doneSide = (doneSide == 1) ? 3 : 2;
      if (dQ.size() != 0) checkOutput("dload", cif.dload, dQ.pop_front());
      else checkOutput("dSpuriousDone", 32'(cif.dwait), 32'd1);
    end else begin
      checkOutput("dloadIdle", cif.dload, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expSeq[10];
    int expCnt[10];
    int k;
    bit iDone;
    bit dDone;
    expSeq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    expCnt = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    mem[32'h0000_0040] = 32'hDEAD_BEEF;
    ramstate = FREE;
    ramload  = '0;
    RST = 1'b1;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0);

    // Reset with both requesting
    stepCycle();
    stepCycle();
    checkOutput("rstIwait", 32'(cif.iwait), 32'd1);
    checkOutput("rstDwait", 32'(cif.dwait), 32'd1);
    checkOutput("rstIload", cif.iload, 32'd0);
    checkOutput("rstDload", cif.dload, 32'd0);
    checkOutput("rstRamREN", 32'(ramREN), 32'd0);
    checkOutput("rstRamWEN", 32'(ramWEN), 32'd0);
    checkOutput("rstRamaddr", ramaddr, 32'd0);
    checkOutput("rstRamstore", ramstore, 32'd0);
    checkOutput("rstStarve", 32'(dut.starve_cnt), 32'd0);

    dQ.push_back(memWord(32'h80));
    RST = 1'b0;
    stepCycle();
    checkOutput("firstGrantSide", 32'(doneSide), 32'd2);
    checkOutput("firstGrantAddr", ramaddr, 32'h80);
    checkOutput("firstGrantREN", 32'(ramREN), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("idleRamaddr", ramaddr, 32'd0);
    checkOutput("idleRamREN", 32'(ramREN), 32'd0);
    stepCycle();

    // Icache read with two BUSY cycles
    ramWaitCfg = 2;
    iQ.push_back(32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      checkOutput("icIwait", 32'(cif.iwait), (c == 3) ? 32'd0 : 32'd1);
      checkOutput("icDwait", 32'(cif.dwait), 32'd1);
      checkOutput("icRamREN", 32'(ramREN), (c <= 3) ? 32'd1 : 32'd0);
      if (c == 3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    stepCycle();

    // Dcache write, zero-wait, then read back
    ramWaitCfg = 0;
    dQ.push_back(32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h1234_5678);
    stepCycle();
    checkOutput("dwRamWEN", 32'(ramWEN), 32'd1);
    checkOutput("dwRamREN", 32'(ramREN), 32'd0);
    checkOutput("dwRamaddr", ramaddr, 32'h100);
    checkOutput("dwRamstore", ramstore, 32'h1234_5678);
    checkOutput("dwDwait", 32'(cif.dwait), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("dwDwaitAfter", 32'(cif.dwait), 32'd1);
    checkOutput("dwRamstoreIdle", ramstore, 32'd0);
    dQ.push_back(32'h1234_5678);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    stepCycle();
    checkOutput("drDone", 32'(doneSide), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();

    // Starvation: both held high, zero-wait RAM
    for (int n = 0; n < 2; n++) iQ.push_back(32'hDEAD_BEEF);
    for (int n = 0; n < 8; n++) dQ.push_back(memWord(32'h200));
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h0);
    k = 0;
    for (int t = 0; t < 40 && k < 10; t++) begin
      stepCycle();
      if (doneSide != 0) begin
        checkOutput("starveOrder", 32'(doneSide), 32'(expSeq[k]));
        stepCycle();
        checkOutput("starveCnt", 32'(dut.starve_cnt), 32'(expCnt[k]));
        k++;
      end
    end
    if (k != 10) checkOutput("starveTimeout", 32'(k), 32'd10);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    stepCycle();

    // Abort during BUSY
    ramWaitCfg = 3;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    stepCycle();
    checkOutput("abortBusyREN", 32'(ramREN), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("abortStrobeDrop", 32'(ramREN), 32'd0);
    checkOutput("abortDwait", 32'(cif.dwait), 32'd1);
    stepCycle();
    checkOutput("abortIdle", 32'(dut.state), 32'(ARB_IDLE));
    stepCycle();

    // ERROR for three cycles, then ACCESS
    ramErr = 1'b1;
    iQ.push_back(memWord(32'h44));
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      stepCycle();
      checkOutput("errIwait", 32'(cif.iwait), (c == 4) ? 32'd0 : 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    ramErr = 1'b0;
    stepCycle();

    // Dcache request arriving while icache owns the port is served afterwards
    ramWaitCfg = 2;
    iQ.push_back(32'hDEAD_BEEF);
    dQ.push_back(32'h0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    cif.dWEN   = 1'b1;
    cif.daddr  = 32'h500;
    cif.dstore = 32'hCAFE_F00D;
    iDone = 1'b0;
    dDone = 1'b0;
    for (int t = 0; t < 20 && !(iDone && dDone); t++) begin
      stepCycle();
      if (doneSide == 1) begin
        iDone = 1'b1;
        checkOutput("queuedDPending", 32'(dDone), 32'd0);
        cif.iREN = 1'b0;
      end
      if (doneSide == 2) begin
        dDone = 1'b1;
        cif.dWEN = 1'b0;
      end
    end
    checkOutput("queuedBothDone", {30'd0, iDone, dDone}, 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    ramWaitCfg = 0;
    dQ.push_back(32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();

    // Reset in the middle of a transaction
    ramWaitCfg = 5;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0);
    stepCycle();
    checkOutput("midRstBusyREN", 32'(ramREN), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("midRstStrobe", 32'(ramREN), 32'd0);
    checkOutput("midRstRamaddr", ramaddr, 32'd0);
    checkOutput("midRstDwait", 32'(cif.dwait), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    stepCycle();
    RST = 1'b0;
    stepCycle();
    checkOutput("midRstIdle", 32'(dut.state), 32'(ARB_IDLE));

    checkOutput("iQueueDrained", 32'(iQ.size()), 32'd0);
    checkOutput("dQueueDrained", 32'(dQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
